router_dest_reader: RTL and testbench
=====================================

Name: router_dest_reader

Overview:
- Destination-side packet reader for one output port of the 1x3 router.
- Drains the port's output FIFO using the read_enb/valid_out handshake, then rebuilds the packet: header, payload, parity.
- Streams payload bytes to the local consumer, checks parity and reports per-packet status.
- Packet format: header [7:2] = payload length L (0..63), [1:0] = dest addr; then L payload bytes; then a parity byte equal to the XOR of the header and all payload bytes.

Parameters:
- TIMEOUT_CYCLES, 30, consecutive BODY cycles with valid_in low before the packet is aborted.
- STAT_W, 16, width of the statistics counters.

Ports:
- clock  input  1  single clock; all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- valid_in  input  1  FIFO non-empty indication from router (valid_out of the port).
- rd_data  input  8  FIFO read data; valid one cycle after an accepted read.
- read_enb  output  1  FIFO read request.
- rx_enable  input  1  consumer enable; 0 blocks new reads in IDLE and BODY.
- pay_valid  output  1  one-cycle pulse per payload byte.
- pay_data  output  8  payload byte, qualified by pay_valid.
- pkt_done  output  1  one-cycle pulse at end of packet (good, parity error or timeout).
- pkt_addr  output  2  dest addr of last header; held until next header.
- pkt_len  output  6  length of last header; held until next header.
- parity_err  output  1  valid with pkt_done; parity mismatch.
- timeout_err  output  1  valid with pkt_done; packet aborted by timeout.
- good_cnt  output  STAT_W  good packets (see Optional Feature).
- err_cnt  output  STAT_W  parity/timeout errors (see Optional Feature).

Behaviour:
- Reset: state IDLE. All outputs 0; internal counters and running XOR cleared. Reset is asynchronous: mid-packet assertion abandons the packet with no pkt_done.
- Fire: fire = read_enb & valid_in. Each fire returns rd_data exactly one cycle later (rd_vld = fire registered).
- read_enb is combinational from state, valid_in and rx_enable. It is never high in HDR_WAIT, DRAIN or DONE.
- IDLE: read_enb = valid_in & rx_enable. On fire -> HDR_WAIT.
- HDR_WAIT: capture rd_data as header and load pkt_addr/pkt_len. Set remaining = L+1 (payload bytes plus parity) and xor = header. -> BODY.
- BODY: read_enb = valid_in & rx_enable. Each fire decrements remaining. Each rd_vld byte is either payload or parity:
  - Payload byte: pulse pay_valid with pay_data = byte, xor ^= byte.
  - Exactly one rd_vld byte is parity: the one returned for the fire that took remaining 1 -> 0.
  - When remaining hits 0 on a fire -> DRAIN.
- Read count: the reader never issues more than L+2 fires per packet. The HDR_WAIT bubble guarantees no read is issued before L is known.
- L=0: HDR_WAIT loads remaining=1; a single BODY fire fetches the parity byte.
- DRAIN: the final rd_vld byte is parity. pkt_done=1 next cycle (DONE), parity_err = (parity != xor), timeout_err=0.
- DONE: one cycle, -> IDLE. Back-to-back packets: at most 2 idle cycles between the last fire of one packet and the header fire of the next.
- Timeout: in BODY, a counter increments each cycle valid_in=0 and clears on any valid_in=1. Reaching TIMEOUT_CYCLES -> DONE with pkt_done=1, timeout_err=1, parity_err=0; remaining bytes are not read.
- rx_enable=0 in BODY stalls reads without advancing the timeout counter when valid_in=1.
- Simultaneous: a pay_valid byte and the parity-compare cycle never coincide. A timeout and a fire in the same cycle cannot occur, because a fire clears the counter.
- pay_data holds its last value when pay_valid=0.

Optional Feature:
- Macro: ROUTER_READER_STATS_EN.
- Defined:
  - good_cnt increments on pkt_done with both error flags 0.
  - err_cnt increments on pkt_done with either flag 1.
  - Both saturate at all-ones and are cleared only by resetn.
- Undefined: counter logic absent; good_cnt and err_cnt tied to 0.

Test Plan:
- Good packet: valid_in held high; FIFO returns 0x0D,0x11,0x22,0x33,0x0D -> exactly 5 fires; pay_valid pulses 0x11,0x22,0x33; pkt_done with pkt_addr=1, pkt_len=3, parity_err=0; good_cnt=1 with macro.
- Bad parity: same packet with last byte 0x0C -> pkt_done with parity_err=1; err_cnt=1 with macro.
- L=0 packet: 0x02 then parity 0x02 -> 2 fires, no pay_valid, pkt_done with pkt_addr=2, parity_err=0.
- Timeout: header 0x0D, one payload byte, then valid_in low for 30 cycles -> pkt_done with timeout_err=1 on cycle 30; no further read_enb until valid_in returns.
- Backpressure: rx_enable toggled 1/0 every cycle during 0x0D packet -> read_enb only when both rx_enable and valid_in are high; payload order and parity unchanged; no timeout.
- Reset mid-packet: assert resetn=0 asynchronously after the second payload fire -> outputs 0 immediately, state IDLE; next packet 0x0D... read cleanly.

Source files
------------

// File: rtl/router_dest_reader.sv
// ---------------------------------------------------------------------------
// router_dest_reader
//
// Destination-side packet reader for one output port of the 1x3 router.
// It pops bytes out of the port's output FIFO using the read_enb/valid_in
// handshake and rebuilds each packet. A packet is a header byte, then L
// payload bytes, then one parity byte. The header holds the payload length
// L in bits [7:2] and the destination address in bits [1:0]. The parity
// byte is the XOR of the header and every payload byte.
//
// Payload bytes are streamed to the local consumer. The parity byte is
// checked, and a one-cycle pkt_done pulse reports the status of each packet.
//
// Optional feature: define ROUTER_READER_STATS_EN to build saturating
// good/error packet counters. Without it, good_cnt and err_cnt are tied to 0.
//
// Parameters:
//   TIMEOUT_CYCLES  consecutive BODY cycles with valid_in low before abort
//   STAT_W          width of the statistics counters
//
// Ports:
//   clock        in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   valid_in     in   FIFO non-empty indication
//   rd_data[7:0] in   FIFO data, valid one cycle after an accepted read
//   read_enb     out  FIFO read request (combinational)
//   rx_enable    in   consumer enable; low blocks new reads
//   pay_valid    out  one-cycle pulse per payload byte
//   pay_data     out  payload byte, holds its value between pulses
//   pkt_done     out  one-cycle end-of-packet pulse
//   pkt_addr     out  destination address of the last header
//   pkt_len      out  payload length of the last header
//   parity_err   out  parity mismatch, qualified by pkt_done
//   timeout_err  out  packet aborted by timeout, qualified by pkt_done
//   good_cnt     out  count of good packets (stats build only)
//   err_cnt      out  count of errored packets (stats build only)
// ---------------------------------------------------------------------------
module router_dest_reader #(
   parameter int TIMEOUT_CYCLES = 30,
   parameter int STAT_W         = 16
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              valid_in,
   input  logic [7:0]        rd_data,
   output logic              read_enb,
   input  logic              rx_enable,
   output logic              pay_valid,
   output logic [7:0]        pay_data,
   output logic              pkt_done,
   output logic [1:0]        pkt_addr,
   output logic [5:0]        pkt_len,
   output logic              parity_err,
   output logic              timeout_err,
   output logic [STAT_W-1:0] good_cnt,
   output logic [STAT_W-1:0] err_cnt
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      HDR_WAIT,
      BODY,
      DRAIN,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              fire;
   logic              rd_vld;
   logic [6:0]        remaining;
   logic [7:0]        xor_acc;
   logic [TO_W-1:0]   to_cnt;
   logic              to_hit;
   logic              par_err_q;
   logic              to_err_q;

   assign fire = read_enb & valid_in;

   // State register. An asynchronous reset drops any packet in flight
   // straight back to IDLE without producing a pkt_done pulse.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and the read request.
   // Reads are only issued in IDLE (for the header) and in BODY (for the
   // payload and parity bytes). HDR_WAIT is a deliberate one-cycle bubble:
   // no further read is issued until the length field is known, so the
   // reader never over-reads into the next packet.
   // In BODY, the fire that takes 'remaining' from 1 to 0 fetches the parity
   // byte. That byte arrives in DRAIN, so every byte seen in BODY is payload.
   // The timeout only advances while valid_in is low. A fire needs valid_in
   // high, so a fire and a timeout can never happen in the same cycle.
   always_comb begin
      state_nxt = state;
      read_enb  = 1'b0;
      to_hit    = 1'b0;
      case (state)
         IDLE: begin
            read_enb = valid_in & rx_enable;
            if (valid_in && rx_enable) begin
               state_nxt = HDR_WAIT;
            end
         end
         HDR_WAIT: begin
            state_nxt = BODY;
         end
         BODY: begin
            read_enb = valid_in & rx_enable;
            if (valid_in && rx_enable && remaining == 7'd1) begin
               state_nxt = DRAIN;
            end else if (!valid_in && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
               state_nxt = DONE;
               to_hit    = 1'b1;
            end
         end
         DRAIN: begin
            state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: the header capture, the remaining-byte count, the running
   // XOR, the timeout counter, the payload output register and the error
   // flags.
   // rd_vld marks the cycle in which the data for the previous fire sits on
   // rd_data. pay_valid and pay_data are registered, so each payload pulse
   // trails its byte by one cycle. pay_data keeps its value between pulses.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_vld    <= 1'b0;
         remaining <= '0;
         xor_acc   <= '0;
         to_cnt    <= '0;
         pay_valid <= 1'b0;
         pay_data  <= '0;
         pkt_addr  <= '0;
         pkt_len   <= '0;
         par_err_q <= 1'b0;
         to_err_q  <= 1'b0;
      end else begin
         rd_vld    <= fire;
         pay_valid <= 1'b0;
         case (state)
            HDR_WAIT: begin
               pkt_addr  <= rd_data[1:0];
               pkt_len   <= rd_data[7:2];
               remaining <= {1'b0, rd_data[7:2]} + 7'd1;
               xor_acc   <= rd_data;
               to_cnt    <= '0;
            end
            BODY: begin
               if (fire) begin
                  remaining <= remaining - 7'd1;
               end
               if (rd_vld) begin
                  pay_valid <= 1'b1;
                  pay_data  <= rd_data;
                  xor_acc   <= xor_acc ^ rd_data;
               end
               if (valid_in) begin
                  to_cnt <= '0;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
               if (to_hit) begin
                  to_err_q  <= 1'b1;
                  par_err_q <= 1'b0;
               end
            end
            DRAIN: begin
               par_err_q <= (rd_data != xor_acc);
               to_err_q  <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   // Status is presented only during the single DONE cycle. This keeps the
   // error flags from looking asserted between packets.
   assign pkt_done    = (state == DONE);
   assign parity_err  = pkt_done & par_err_q;
   assign timeout_err = pkt_done & to_err_q;

`ifdef ROUTER_READER_STATS_EN
   logic [STAT_W-1:0] good_q;
   logic [STAT_W-1:0] err_q;

   // Saturating packet statistics. A packet counts as good only if neither
   // error flag is set. Only resetn clears the counters.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         good_q <= '0;
         err_q  <= '0;
      end else if (pkt_done) begin
         if (par_err_q || to_err_q) begin
            if (err_q != '1) begin
               err_q <= err_q + STAT_W'(1);
            end
         end else begin
            if (good_q != '1) begin
               good_q <= good_q + STAT_W'(1);
            end
         end
      end
   end

   assign good_cnt = good_q;
   assign err_cnt  = err_q;
`else
   assign good_cnt = '0;
   assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_router_dest_reader.sv
// ---------------------------------------------------------------------------
// tb_router_dest_reader
//
// Directed, self-checking bench for router_dest_reader. A queue models the
// router's output FIFO:
//   - valid_in means the queue is not empty.
//   - An accepted read pops the next byte onto rd_data one cycle later.
// Payload pulses, pkt_done status and the fire count are collected each
// cycle. Each test then checks them against hand-computed packet contents.
// ---------------------------------------------------------------------------
module tb_router_dest_reader;

`ifdef ROUTER_READER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        resetn;
   logic        valid_in;
   logic [7:0]  rd_data;
   logic        read_enb;
   logic        rx_enable;
   logic        pay_valid;
   logic [7:0]  pay_data;
   logic        pkt_done;
   logic [1:0]  pkt_addr;
   logic [5:0]  pkt_len;
   logic        parity_err;
   logic        timeout_err;
   logic [15:0] good_cnt;
   logic [15:0] err_cnt;

   logic [7:0]  fifo[$];
   logic [7:0]  pay_q[$];
   int          fire_cnt;
   int          done_cnt;
   logic        last_perr;
   logic        last_terr;
   logic [1:0]  last_addr;
   logic [5:0]  last_len;
   bit          toggle_en;
   bit          enb_bad;
   int          compared;
   int          mismatched;

   router_dest_reader #(
      .TIMEOUT_CYCLES(30),
      .STAT_W(16)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .valid_in(valid_in),
      .rd_data(rd_data),
      .read_enb(read_enb),
      .rx_enable(rx_enable),
      .pay_valid(pay_valid),
      .pay_data(pay_data),
      .pkt_done(pkt_done),
      .pkt_addr(pkt_addr),
      .pkt_len(pkt_len),
      .parity_err(parity_err),
      .timeout_err(timeout_err),
      .good_cnt(good_cnt),
      .err_cnt(err_cnt)
   );

   // Free-running 10-time-unit clock.
   always #5 clock = ~clock;

   // Global watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1, "[TB] watchdog expired");
   end

   // One clock cycle of the FIFO model.
   // Outputs are observed at the falling edge. The fire decision uses the
   // same values the DUT samples at the rising edge. Inputs then change just
   // after the rising edge.
   task automatic step();
      logic f;
      @(negedge clock);
      if (pay_valid) pay_q.push_back(pay_data);
      if (pkt_done) begin
         done_cnt++;
         last_perr = parity_err;
         last_terr = timeout_err;
         last_addr = pkt_addr;
         last_len  = pkt_len;
      end
      if (read_enb && !(valid_in && rx_enable)) enb_bad = 1'b1;
      f = read_enb & valid_in;
      if (f) fire_cnt++;
      @(posedge clock);
      #1;
      if (f) rd_data = fifo.pop_front();
      valid_in = (fifo.size() != 0);
      if (toggle_en) rx_enable = ~rx_enable;
   endtask

   task automatic clear_obs();
      fire_cnt = 0;
      done_cnt = 0;
      pay_q.delete();
      enb_bad  = 1'b0;
   endtask

   task automatic run_until_done(input int max_cycles, output bit ok);
      int n;
      n = 0;
      while (done_cnt == 0 && n < max_cycles) begin
         step();
         n++;
      end
      ok = (done_cnt != 0);
   endtask

   task automatic test_reset();
      resetn    = 1'b0;
      valid_in  = 1'b0;
      rx_enable = 1'b1;
      rd_data   = 8'h00;
      toggle_en = 1'b0;
      #12;
      compared++;
      if ({read_enb, pay_valid, pkt_done, parity_err, timeout_err} !== 5'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_flags: got %b, required 00000",
                  {read_enb, pay_valid, pkt_done, parity_err, timeout_err});
      end
      compared++;
      if ({pay_data, pkt_addr, pkt_len} !== 16'h0000) begin
         mismatched++;
         $display("[TB] FAIL reset_fields: got %h, required 0000", {pay_data, pkt_addr, pkt_len});
      end
      compared++;
      if ({good_cnt, err_cnt} !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_counters: got %h, required 0", {good_cnt, err_cnt});
      end
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_good_packet();
      bit ok;
      logic [23:0] got;
      $display("[TB] good packet");
      clear_obs();
      fifo = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      valid_in = 1'b1;
      run_until_done(100, ok);
      compared++;
      if (!ok) begin
         mismatched++;
         $display("[TB] FAIL good_done: pkt_done not seen within 100 cycles, required one");
      end
      compared++;
      if (fire_cnt != 5) begin
         mismatched++;
         $display("[TB] FAIL good_fires: got %0d, required 5", fire_cnt);
      end
      got = (pay_q.size() == 3) ? {pay_q[0], pay_q[1], pay_q[2]} : 24'hFFFFFF;
      compared++;
      if (got !== 24'h112233) begin
         mismatched++;
         $display("[TB] FAIL good_payload: got %h (%0d bytes), required 112233", got, pay_q.size());
      end
      compared++;
      if ({last_addr, last_len, last_perr, last_terr} !== {2'd1, 6'd3, 1'b0, 1'b0}) begin
         mismatched++;
         $display("[TB] FAIL good_status: got addr=%0d len=%0d perr=%b terr=%b, required 1 3 0 0",
                  last_addr, last_len, last_perr, last_terr);
      end
      compared++;
      if (good_cnt !== (STATS ? 16'd1 : 16'd0) || err_cnt !== 16'd0) begin
         mismatched++;
         $display("[TB] FAIL good_counters: got good=%0d err=%0d, required good=%0d err=0",
                  good_cnt, err_cnt, STATS ? 1 : 0);
      end
   endtask

   task automatic test_bad_parity();
      bit ok;
      logic [23:0] got;
      $display("[TB] bad parity");
      clear_obs();
      fifo = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C};
      valid_in = 1'b1;
      run_until_done(100, ok);
      compared++;
      if (!ok) begin
         mismatched++;
         $display("[TB] FAIL bad_done: pkt_done not seen within 100 cycles, required one");
      end
      got = (pay_q.size() == 3) ? {pay_q[0], pay_q[1], pay_q[2]} : 24'hFFFFFF;
      compared++;
      if (got !== 24'h112233) begin
         mismatched++;
         $display("[TB] FAIL bad_payload: got %h, required 112233", got);
      end
      compared++;
      if ({last_perr, last_terr} !== 2'b10) begin
         mismatched++;
         $display("[TB] FAIL bad_flags: got perr=%b terr=%b, required 1 0", last_perr, last_terr);
      end
      compared++;
      if (good_cnt !== (STATS ? 16'd1 : 16'd0) || err_cnt !== (STATS ? 16'd1 : 16'd0)) begin
         mismatched++;
         $display("[TB] FAIL bad_counters: got good=%0d err=%0d, required %0d %0d",
                  good_cnt, err_cnt, STATS ? 1 : 0, STATS ? 1 : 0);
      end
   endtask

   task automatic test_zero_len();
      bit ok;
      $display("[TB] zero-length packet");
      clear_obs();
      fifo = '{8'h02, 8'h02};
      valid_in = 1'b1;
      run_until_done(100, ok);
      compared++;
      if (!ok || fire_cnt != 2) begin
         mismatched++;
         $display("[TB] FAIL zero_fires: got done=%b fires=%0d, required done=1 fires=2", ok, fire_cnt);
      end
      compared++;
      if (pay_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL zero_payload: got %0d payload pulses, required 0", pay_q.size());
      end
      compared++;
      if ({last_addr, last_len, last_perr, last_terr} !== {2'd2, 6'd0, 1'b0, 1'b0}) begin
         mismatched++;
         $display("[TB] FAIL zero_status: got addr=%0d len=%0d perr=%b terr=%b, required 2 0 0 0",
                  last_addr, last_len, last_perr, last_terr);
      end
      compared++;
      if (good_cnt !== (STATS ? 16'd2 : 16'd0)) begin
         mismatched++;
         $display("[TB] FAIL zero_good_cnt: got %0d, required %0d", good_cnt, STATS ? 2 : 0);
      end
   endtask

   task automatic test_timeout();
      int  n;
      int  guard;
      bit  seen_done;
      bit  pay_seen;
      bit  enb_seen;
      logic [7:0] pay_byte;
      $display("[TB] timeout");
      clear_obs();
      fifo = '{8'h0D, 8'h11};
      valid_in = 1'b1;
      guard = 0;
      while (fire_cnt < 2 && guard < 20) begin
         step();
         guard++;
      end
      compared++;
      if (fire_cnt != 2 || valid_in !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL timeout_setup: got fires=%0d valid_in=%b, required 2 0", fire_cnt, valid_in);
      end
      n         = 0;
      seen_done = 1'b0;
      pay_seen  = 1'b0;
      enb_seen  = 1'b0;
      pay_byte  = 8'h00;
      while (!seen_done && n < 40) begin
         @(posedge clock);
         #1;
         n++;
         if (read_enb) enb_seen = 1'b1;
         if (pay_valid) begin
            pay_seen = 1'b1;
            pay_byte = pay_data;
         end
         if (pkt_done) begin
            seen_done = 1'b1;
            last_perr = parity_err;
            last_terr = timeout_err;
            last_len  = pkt_len;
            last_addr = pkt_addr;
         end
      end
      compared++;
      if (!seen_done || n != 30) begin
         mismatched++;
         $display("[TB] FAIL timeout_cycle: got done=%b after %0d idle cycles, required done on cycle 30",
                  seen_done, n);
      end
      compared++;
      if ({last_terr, last_perr, last_addr, last_len} !== {1'b1, 1'b0, 2'd1, 6'd3}) begin
         mismatched++;
         $display("[TB] FAIL timeout_flags: got terr=%b perr=%b addr=%0d len=%0d, required 1 0 1 3",
                  last_terr, last_perr, last_addr, last_len);
      end
      compared++;
      if (!pay_seen || pay_byte !== 8'h11) begin
         mismatched++;
         $display("[TB] FAIL timeout_payload: got seen=%b byte=%h, required 1 11", pay_seen, pay_byte);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #1;
         if (read_enb) enb_seen = 1'b1;
      end
      compared++;
      if (enb_seen) begin
         mismatched++;
         $display("[TB] FAIL timeout_read_enb: got read_enb=1 while valid_in low, required 0");
      end
      compared++;
      if (err_cnt !== (STATS ? 16'd2 : 16'd0)) begin
         mismatched++;
         $display("[TB] FAIL timeout_err_cnt: got %0d, required %0d", err_cnt, STATS ? 2 : 0);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [23:0] got;
      $display("[TB] backpressure");
      clear_obs();
      fifo = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      rx_enable = 1'b1;
      toggle_en = 1'b1;
      valid_in  = 1'b1;
      run_until_done(200, ok);
      toggle_en = 1'b0;
      rx_enable = 1'b1;
      compared++;
      if (!ok || fire_cnt != 5) begin
         mismatched++;
         $display("[TB] FAIL bp_fires: got done=%b fires=%0d, required done=1 fires=5", ok, fire_cnt);
      end
      compared++;
      if (enb_bad) begin
         mismatched++;
         $display("[TB] FAIL bp_read_enb: got read_enb high without rx_enable&valid_in, required never");
      end
      got = (pay_q.size() == 3) ? {pay_q[0], pay_q[1], pay_q[2]} : 24'hFFFFFF;
      compared++;
      if (got !== 24'h112233) begin
         mismatched++;
         $display("[TB] FAIL bp_payload: got %h, required 112233", got);
      end
      compared++;
      if ({last_perr, last_terr} !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL bp_flags: got perr=%b terr=%b, required 0 0", last_perr, last_terr);
      end
      compared++;
      if (good_cnt !== (STATS ? 16'd3 : 16'd0)) begin
         mismatched++;
         $display("[TB] FAIL bp_good_cnt: got %0d, required %0d", good_cnt, STATS ? 3 : 0);
      end
   endtask

   task automatic test_reset_mid_packet();
      bit ok;
      int guard;
      logic [23:0] got;
      $display("[TB] reset mid-packet");
      clear_obs();
      fifo = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      valid_in = 1'b1;
      guard = 0;
      while (fire_cnt < 3 && guard < 20) begin
         step();
         guard++;
      end
      #2;
      resetn = 1'b0;
      #1;
      compared++;
      if ({pay_valid, pkt_done, parity_err, timeout_err} !== 4'b0 ||
          {pay_data, pkt_addr, pkt_len} !== 16'h0000) begin
         mismatched++;
         $display("[TB] FAIL midreset_outputs: got flags=%b fields=%h, required 0 0000",
                  {pay_valid, pkt_done, parity_err, timeout_err}, {pay_data, pkt_addr, pkt_len});
      end
      compared++;
      if ({good_cnt, err_cnt} !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL midreset_counters: got %h, required 0", {good_cnt, err_cnt});
      end
      fifo.delete();
      valid_in = 1'b0;
      rd_data  = 8'h00;
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock);
      #1;
      compared++;
      if (done_cnt != 0 || pkt_done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL midreset_no_done: got done_cnt=%0d pkt_done=%b, required 0 0", done_cnt, pkt_done);
      end
      clear_obs();
      fifo = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      valid_in = 1'b1;
      run_until_done(100, ok);
      got = (pay_q.size() == 3) ? {pay_q[0], pay_q[1], pay_q[2]} : 24'hFFFFFF;
      compared++;
      if (!ok || fire_cnt != 5 || got !== 24'h112233) begin
         mismatched++;
         $display("[TB] FAIL midreset_next_packet: got done=%b fires=%0d payload=%h, required 1 5 112233",
                  ok, fire_cnt, got);
      end
      compared++;
      if ({last_addr, last_len, last_perr, last_terr} !== {2'd1, 6'd3, 1'b0, 1'b0}) begin
         mismatched++;
         $display("[TB] FAIL midreset_status: got addr=%0d len=%0d perr=%b terr=%b, required 1 3 0 0",
                  last_addr, last_len, last_perr, last_terr);
      end
      compared++;
      if (good_cnt !== (STATS ? 16'd1 : 16'd0) || err_cnt !== 16'd0) begin
         mismatched++;
         $display("[TB] FAIL midreset_stats: got good=%0d err=%0d, required %0d 0",
                  good_cnt, err_cnt, STATS ? 1 : 0);
      end
   endtask

   // Test sequence. The statistics counters accumulate across tests until
   // the mid-packet reset clears them.
   initial begin
      compared   = 0;
      mismatched = 0;
      clear_obs();
      test_reset();
      test_good_packet();
      test_bad_parity();
      test_zero_len();
      test_timeout();
      test_backpressure();
      test_reset_mid_packet();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
